// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline MEM stage. Registers the EXE-side control/data to the
//                WB stage and performs a single data-memory access per memory
//                op against a word-addressed RAM mapped at BASE_ADDR.
//                Loads read the addressed word before any same-edge store
//                (read-before-write). Out-of-range accesses drop stores and
//                return 0 for loads.
//
//  Optional    : MEM_WAIT_STATE_EN -- when defined, every memory op stalls
//                the pipeline through an IDLE/WAIT FSM for WAIT_CYCLES freeze
//                cycles and completes on the following edge (WAIT_CYCLES+1
//                cycles total). When undefined, freeze is tied to 0 and every
//                access completes in one cycle.
//
//  Ports       : clk          rising-edge clock
//                rst          asynchronous active-low reset
//                WB_EN        write-back enable from EXE
//                MEM_R        load request
//                MEM_W        store request
//                ALU_res      ALU result / byte address
//                val_rm       store data
//                dest         destination register index
//                WB_EN_out    registered write-back enable
//                MEM_R_out    registered load flag (WB mux select)
//                dest_out     registered destination
//                ALU_res_out  registered ALU result
//                mem_data_out registered load data
//                freeze       stall request to upstream stages
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int MEM_WORDS   = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN,
    input  logic        MEM_R,
    input  logic        MEM_W,
    input  logic [31:0] ALU_res,
    input  logic [31:0] val_rm,
    input  logic [3:0]  dest,
    output logic        WB_EN_out,
    output logic        MEM_R_out,
    output logic [3:0]  dest_out,
    output logic [31:0] ALU_res_out,
    output logic [31:0] mem_data_out,
    output logic        freeze
);

    localparam int C_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // Data memory: intentionally not reset so contents survive a pipeline reset.
    logic [31:0] r_mem [MEM_WORDS];

    logic [31:0]        w_offset;
    logic [31:0]        w_word;
    logic               w_in_range;
    logic [C_IDX_W-1:0] w_idx;
    logic [31:0]        w_rd_data;
    logic               w_mem_op;
    logic               w_freeze;
    logic               w_mem_we;

    // Byte address -> word index; the low two address bits are don't-care.
    // The lower-bound test is needed because the subtraction wraps below BASE_ADDR.
    assign w_offset   = ALU_res - 32'(BASE_ADDR);
    assign w_word     = w_offset >> 2;
    assign w_in_range = (ALU_res >= 32'(BASE_ADDR)) && (w_word < 32'(MEM_WORDS));
    assign w_idx      = w_word[C_IDX_W-1:0];
    assign w_rd_data  = w_in_range ? r_mem[w_idx] : 32'd0;
    assign w_mem_op   = MEM_R | MEM_W;

`ifdef MEM_WAIT_STATE_EN
    localparam int C_CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;

    // IDLE: a memory op stalls immediately (combinationally) so upstream holds it.
    // WAIT: stall until the last count; that final edge performs the access.
    assign w_freeze = (r_state == S_IDLE) ? w_mem_op : (r_cnt != C_CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_mem_op) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
`else
    assign w_freeze = 1'b0;
`endif

    assign freeze = w_freeze;

    // Stores happen only on the completing edge; gating with rst keeps a
    // reset-held pipeline from corrupting memory.
    assign w_mem_we = rst && !w_freeze && MEM_W && w_in_range;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= val_rm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN_out    <= 1'b0;
            MEM_R_out    <= 1'b0;
            dest_out     <= 4'd0;
            ALU_res_out  <= 32'd0;
            mem_data_out <= 32'd0;
        end else if (w_freeze) begin
            // Bubble: nothing retires while the access is pending.
            WB_EN_out <= 1'b0;
            MEM_R_out <= 1'b0;
        end else begin
            WB_EN_out   <= WB_EN;
            MEM_R_out   <= MEM_R;
            dest_out    <= dest;
            ALU_res_out <= ALU_res;
            // Load data holds across non-memory ops; the read sees the
            // pre-write word on a simultaneous store.
            if (w_mem_op) begin
                mem_data_out <= w_rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Directed vector table for
//                the mapping/pass-through/read-before-write behaviour, plus a
//                hand-written asynchronous reset sequence. Wait-state checks
//                are active when MEM_WAIT_STATE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int WAIT_CYCLES = 2;

    logic        clk;
    logic        rst;
    logic        WB_EN;
    logic        MEM_R;
    logic        MEM_W;
    logic [31:0] ALU_res;
    logic [31:0] val_rm;
    logic [3:0]  dest;
    logic        WB_EN_out;
    logic        MEM_R_out;
    logic [3:0]  dest_out;
    logic [31:0] ALU_res_out;
    logic [31:0] mem_data_out;
    logic        freeze;

    int checks = 0;
    int errors = 0;

    mem_stage #(
        .MEM_WORDS   (64),
        .BASE_ADDR   (1024),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .WB_EN        (WB_EN),
        .MEM_R        (MEM_R),
        .MEM_W        (MEM_W),
        .ALU_res      (ALU_res),
        .val_rm       (val_rm),
        .dest         (dest),
        .WB_EN_out    (WB_EN_out),
        .MEM_R_out    (MEM_R_out),
        .dest_out     (dest_out),
        .ALU_res_out  (ALU_res_out),
        .mem_data_out (mem_data_out),
        .freeze       (freeze)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic        wb;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  dst;
        logic        chk_mdo;
        logic [31:0] exp_mdo;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        MEM_R   = v.re;
        MEM_W   = v.we;
        WB_EN   = v.wb;
        ALU_res = v.addr;
        val_rm  = v.data;
        dest    = v.dst;
    endtask

    // Applies one vector, waits out any stall, then checks the completing edge.
    task automatic run_vec(input int i);
        vec_t v;
        int   n;
        v = vecs[i];
        drive(v);
        #1;
        n = 0;
`ifdef MEM_WAIT_STATE_EN
        while (freeze && n < 50) begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d bubble wb", i), {31'd0, WB_EN_out}, 32'd0);
            n++;
        end
        chk($sformatf("v%0d freeze cycles", i), n, (v.re | v.we) ? WAIT_CYCLES : 0);
`endif
        chk($sformatf("v%0d freeze before edge", i), {31'd0, freeze}, 32'd0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d wb_out", i), {31'd0, WB_EN_out}, {31'd0, v.wb});
        chk($sformatf("v%0d mem_r_out", i), {31'd0, MEM_R_out}, {31'd0, v.re});
        chk($sformatf("v%0d dest_out", i), {28'd0, dest_out}, {28'd0, v.dst});
        chk($sformatf("v%0d alu_out", i), ALU_res_out, v.addr);
        if (v.chk_mdo) begin
            chk($sformatf("v%0d mem_data_out", i), mem_data_out, v.exp_mdo);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " wb_out"},    {31'd0, WB_EN_out}, 32'd0);
        chk({tag, " mem_r_out"}, {31'd0, MEM_R_out}, 32'd0);
        chk({tag, " dest_out"},  {28'd0, dest_out},  32'd0);
        chk({tag, " alu_out"},   ALU_res_out,        32'd0);
        chk({tag, " mdo"},       mem_data_out,       32'd0);
        chk({tag, " freeze"},    {31'd0, freeze},    32'd0);
    endtask

    initial begin
        //            re    we    wb    addr          data          dst   chk   exp_mdo
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'd1024,     32'hDEADBEEF, 4'd0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'd1024,     32'h0,        4'd5, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'd1027,     32'h11,       4'd0, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'd1024,     32'h0,        4'd1, 1'b1, 32'h11};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd1276,     32'h22,       4'd0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'd1276,     32'h0,        4'd2, 1'b1, 32'h22};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'd1280,     32'h33,       4'd0, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'd1280,     32'h0,        4'd4, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'd1024,     32'h0,        4'd6, 1'b1, 32'h11};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd1020,     32'h0,        4'd7, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h55,       32'h0,        4'd3, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'd1024,     32'h99,       4'd8, 1'b1, 32'h11};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'd1024,     32'h0,        4'd9, 1'b1, 32'h99};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'd7,        32'h0,        4'd2, 1'b1, 32'h99};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 32'd1024,     32'h0,        4'd9, 1'b1, 32'h99};

        rst = 1'b0;
        drive('{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0});
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(i);
        end

        // Asynchronous reset with a load in flight (mid-WAIT when wait states exist).
        drive(vecs[14]);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("async reset");
        #3;
        rst = 1'b1;
        // Memory survives reset and a fresh load runs the full sequence.
        run_vec(14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
